filter_bank_scheduler: RTL
==========================

# filter_bank_scheduler

Time-multiplexed sequencer that computes the three-band (bajos/medios/altos) crossover filter bank with one shared multiply-accumulate unit instead of six parallel biquads. Each input sample runs through six Direct Form I biquad sections in a fixed order: LPB→HPB, LPM→HPM, LPH→HPH. The block owns the coefficient register file, loaded through a configuration port, and the per-section history registers. It sits between the audio sample source and the band gain/mixing stage.

## Interface
- Magnitud, 8, integer bits of the fixed-point format
- Decimal, 14, fractional bits
- N, Magnitud+Decimal+1, total signed width (23)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- sample_valid  in  1  one-cycle strobe; Data_In valid
- Data_In  in  N  signed input sample
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  5  section*5 + coef index (0=b0,1=b1,2=b2,3=a1,4=a2); sections 0..5 = LPB,HPB,LPM,HPM,LPH,HPH
- cfg_data  in  N  signed coefficient; a1/a2 stored already negated
- cfg_ack  out  1  one-cycle pulse: write accepted
- busy  out  1  high while a sample is being processed
- out_valid  out  1  one-cycle pulse: band outputs updated
- overrun  out  1  sticky; sample_valid arrived while not IDLE
- Data_Out_bajos, Data_Out_medios, Data_Out_altos  out  N each  signed band outputs (HPB, HPM, HPH results)

## Operation
- FSM states: IDLE, MAC, WB, DONE.
- IDLE + sample_valid: latch Data_In as x, set sec=0, k=0, clear acc, go to MAC.
- MAC (k=0..4): acc += coef[sec][k] * operand[k], where operands are x, x1, x2, y1, y2 of the current section. After k=4, go to WB.
- Product is 2N bits, accumulator 2N+3 bits, signed throughout.
- WB: y = acc >>> Decimal, then saturate or wrap to N bits (see Configuration).
- WB history update: x2←x1, x1←x, y2←y1, y1←y.
- WB section routing: section input for odd sections = y of the preceding even section; input for sections 2 and 4 = latched sample.
- WB sequencing: sec<5 → sec++, k=0, acc=0, MAC; sec=5 → DONE.
- DONE: register y of sections 1, 3 and 5 onto Data_Out_bajos/medios/altos; pulse out_valid; go to IDLE.
- sample_valid outside IDLE: the sample is dropped, overrun is set, and processing is unaffected. overrun clears only on reset.
- Config write (cfg_we=1, cfg_addr<30) in IDLE without a simultaneous sample_valid: coefficient written, cfg_ack pulses the next cycle.
- Config writes that are ignored with no cfg_ack:
  - cfg_addr≥30;
  - busy;
  - simultaneous with an accepted sample_valid (the sample wins).
- Reset values:
  - all outputs 0;
  - all coefficients and history 0;
  - FSM IDLE, busy=0, overrun=0.
- Reset mid-operation aborts the sample; no out_valid is produced.

## Timing
- Accepting edge T (sample_valid sampled in IDLE): busy=1 from T.
- Six sections × 6 edges (5 MAC + 1 WB) occupy edges T+1..T+36.
- DONE at edge T+37: outputs update, out_valid=1 for one cycle, busy=0.
- Latency sample_valid→out_valid is 37 cycles. Minimum sample period is 38 cycles; next sample is accepted at edge T+38.
- Outputs hold between out_valid pulses.
- cfg_ack pulses one cycle after the write edge.

## Configuration
- FILTER_SAT_EN defined: WB result is clamped to [−2^(N−1), 2^(N−1)−1], i.e. 0x400000..0x3FFFFF.
- FILTER_SAT_EN undefined: WB result is the low N bits of acc >>> Decimal (two's-complement wrap). No other behaviour changes.

## Test plan
- Reset: all outputs 0, busy=0, overrun=0; sample_valid with Data_In=0x001000 → out_valid at +37 cycles, all bands 0 because coefficients are zero.
- Pass-through: write b0=0x004000 (1.0) for all six sections, other coefficients 0. Data_In=0x002000 → all three bands=0x002000 after 37 cycles.
- Impulse into section 0: b0=0x004000, a1=0x002000 (y += 0.5·y1), section 1 as pass-through, others 0. Inputs 0x004000, 0, 0 → Data_Out_bajos = 0x004000, 0x002000, 0x001000.
- Saturation: b0=0x008000 (2.0) on all sections, Data_In=0x3FFFFF → bands=0x3FFFFF with FILTER_SAT_EN. Without the macro, bands equal the wrapped value.
- Overrun and config while busy: second sample_valid at T+10 → dropped, overrun=1 sticky, first result unchanged. cfg_we at T+5 → no cfg_ack, coefficient unchanged. cfg_addr=30 in IDLE → no ack.
- Reset mid-run: assert reset at T+20 → no out_valid, outputs and history 0. The next sample behaves exactly as the first after power-up.

Source files
------------

// File: rtl/filter_bank_scheduler_if.sv
// Sample, coefficient-configuration and band-output bundle for filter_bank_scheduler.
// The source/config side uses the master modport and the scheduler uses the slave modport.
interface filter_bank_scheduler_if #(
  parameter int N = 23
);

  logic                sample_valid;
  logic signed [N-1:0] Data_In;
  logic                cfg_we;
  logic [4:0]          cfg_addr;
  logic signed [N-1:0] cfg_data;
  logic                cfg_ack;
  logic                busy;
  logic                out_valid;
  logic                overrun;
  logic signed [N-1:0] Data_Out_bajos;
  logic signed [N-1:0] Data_Out_medios;
  logic signed [N-1:0] Data_Out_altos;

  modport master (
    output sample_valid, Data_In, cfg_we, cfg_addr, cfg_data,
    input  cfg_ack, busy, out_valid, overrun,
           Data_Out_bajos, Data_Out_medios, Data_Out_altos
  );

  modport slave (
    input  sample_valid, Data_In, cfg_we, cfg_addr, cfg_data,
    output cfg_ack, busy, out_valid, overrun,
           Data_Out_bajos, Data_Out_medios, Data_Out_altos
  );

endinterface

// File: rtl/filter_bank_scheduler.sv
// Three-band crossover built from six Direct Form I biquads sharing a single multiply-accumulate unit.
// Define FILTER_SAT_EN to clamp each section result; without it, results wrap to N bits.
module filter_bank_scheduler #(
  parameter int Magnitud = 8,
  parameter int Decimal  = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  filter_bank_scheduler_if.slave bus
);

  localparam int N     = Magnitud + Decimal + 1;
  localparam int PW    = 2 * N;
  localparam int AW    = 2 * N + 3;
  localparam int NSEC  = 6;
  localparam int NCOEF = 30;

  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          sec_q, sec_d;
  logic [2:0]          k_q, k_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [N-1:0] sample_q;
  logic signed [N-1:0] coef_q [NCOEF];
  logic signed [N-1:0] x1_q [NSEC];
  logic signed [N-1:0] x2_q [NSEC];
  logic signed [N-1:0] y1_q [NSEC];
  logic signed [N-1:0] y2_q [NSEC];
  logic signed [N-1:0] bajos_q, medios_q, altos_q;
  logic                outValid_q, cfgAck_q, overrun_q;

  logic                idle, accept, cfgWrite, macEn, wbEn, doneEn;
  logic signed [N-1:0] secIn, operand, yWb;
  logic [4:0]          coefIdx;
  logic signed [PW-1:0] product;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sec_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (bus.sample_valid) begin
          state_d = MAC;
          sec_d   = '0;
          k_d     = '0;
        end
      end
      MAC: begin
        if (k_q == 3'd4) state_d = WB;
        else             k_d     = k_q + 3'd1;
      end
      WB: begin
        if (sec_q == 3'd5) begin
          state_d = DONE;
        end else begin
          state_d = MAC;
          sec_d   = sec_q + 3'd1;
          k_d     = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A sample in IDLE always wins over a simultaneous coefficient write.
  always_comb begin
    idle     = (state_q == IDLE);
    accept   = idle && bus.sample_valid;
    cfgWrite = idle && bus.cfg_we && !bus.sample_valid && (bus.cfg_addr < 5'd30);
    macEn    = (state_q == MAC);
    wbEn     = (state_q == WB);
    doneEn   = (state_q == DONE);
  end

  // Odd sections are fed by the freshly written y of the even section just before them.
  always_comb begin
    secIn = sec_q[0] ? y1_q[{sec_q[2:1], 1'b0}] : sample_q;
    case (k_q)
      3'd0:    operand = secIn;
      3'd1:    operand = x1_q[sec_q];
      3'd2:    operand = x2_q[sec_q];
      3'd3:    operand = y1_q[sec_q];
      default: operand = y2_q[sec_q];
    endcase
  end

  assign coefIdx = 5'(sec_q) * 5'd5 + 5'(k_q);
  assign product = PW'(coef_q[coefIdx]) * PW'(operand);

  always_comb begin
    acc_d = acc_q;
    if (accept || wbEn) acc_d = '0;
    else if (macEn)     acc_d = acc_q + AW'(product);
  end

`ifdef FILTER_SAT_EN
  // The shifted value fits in N bits only when every bit from the result sign upward agrees.
  always_comb begin
    if ((&acc_q[AW-1:Decimal+N-1]) || !(|acc_q[AW-1:Decimal+N-1]))
      yWb = acc_q[Decimal +: N];
    else if (acc_q[AW-1])
      yWb = {1'b1, {(N-1){1'b0}}};
    else
      yWb = {1'b0, {(N-1){1'b1}}};
  end
`else
  assign yWb = acc_q[Decimal +: N];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      sample_q   <= '0;
      bajos_q    <= '0;
      medios_q   <= '0;
      altos_q    <= '0;
      outValid_q <= 1'b0;
      cfgAck_q   <= 1'b0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < NCOEF; i++) coef_q[i] <= '0;
      for (int i = 0; i < NSEC; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      acc_q      <= acc_d;
      outValid_q <= doneEn;
      cfgAck_q   <= cfgWrite;
      if (bus.sample_valid && !idle) overrun_q <= 1'b1;
      if (accept) sample_q <= bus.Data_In;
      if (cfgWrite) coef_q[bus.cfg_addr] <= bus.cfg_data;
      if (wbEn) begin
        x2_q[sec_q] <= x1_q[sec_q];
        x1_q[sec_q] <= secIn;
        y2_q[sec_q] <= y1_q[sec_q];
        y1_q[sec_q] <= yWb;
      end
      if (doneEn) begin
        bajos_q  <= y1_q[1];
        medios_q <= y1_q[3];
        altos_q  <= y1_q[5];
      end
    end
  end

  assign bus.busy            = !idle;
  assign bus.cfg_ack         = cfgAck_q;
  assign bus.out_valid       = outValid_q;
  assign bus.overrun         = overrun_q;
  assign bus.Data_Out_bajos  = bajos_q;
  assign bus.Data_Out_medios = medios_q;
  assign bus.Data_Out_altos  = altos_q;

endmodule
